tint_signal_monitor: RTL

- Independent lamp-output monitor for the T-intersection signal head, placed on the six lamp lines driven by the traffic controller.
- Decodes the lamp pattern into a phase and checks three things:
  - lamp legality;
  - the MAIN_GREEN → MAIN_YELLOW → SIDE_GREEN → SIDE_YELLOW → MAIN_GREEN sequence;
  - exact per-phase dwell time.
- On the first violation it latches a fault code and holds it until software clears it. Downstream lamp-driver logic uses the fault to force a flashing-red failsafe.

---
 rtl/tint_signal_monitor_if.sv | 29 ++
 rtl/tint_signal_monitor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tint_signal_monitor_if.sv
// Lamp-line and status bundle between the traffic controller side and tint_signal_monitor.
// master: the controller/supervisor side; slave: the monitor.
interface tint_signal_monitor_if;
  logic       main_red;
  logic       main_yellow;
  logic       main_green;
  logic       side_red;
  logic       side_yellow;
  logic       side_green;
  logic       fault_clr;
  logic [1:0] phase;
  logic       locked;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output main_red, main_yellow, main_green,
    output side_red, side_yellow, side_green,
    output fault_clr,
    input  phase, locked, fault, fault_code
  );

  modport slave (
    input  main_red, main_yellow, main_green,
    input  side_red, side_yellow, side_green,
    input  fault_clr,
    output phase, locked, fault, fault_code
  );
endinterface

// File: rtl/tint_signal_monitor.sv
// Independent lamp-output monitor for the T-intersection head: legality, sequence and dwell checks.
// Define TMON_DWELL_CHECK_EN to enable the exact-dwell checks (early/late change codes).
module tint_signal_monitor #(
  parameter int unsigned EXP_DWELL = 250_000_000,
  parameter int unsigned CNT_W     = 28
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tint_signal_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] PH_MAIN_GREEN  = 2'd0;
  localparam logic [1:0] PH_MAIN_YELLOW = 2'd1;
  localparam logic [1:0] PH_SIDE_GREEN  = 2'd2;
  localparam logic [1:0] PH_SIDE_YELLOW = 2'd3;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_SEQ      = 3'd2;
  localparam logic [2:0] CODE_EARLY    = 3'd3;
  localparam logic [2:0] CODE_LATE     = 3'd4;

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] code_q, code_d;
  logic       locked_q, locked_d;
  logic       fault_q, fault_d;
  logic       first_q, first_d;
  logic [1:0] prev_q, prev_d;

`ifdef TMON_DWELL_CHECK_EN
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(EXP_DWELL);
  logic [CNT_W-1:0] dwell_q, dwell_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{CNT_W'(EXP_DWELL)};
`endif

  logic [1:0] samp_c;
  logic       conflict_c;
  logic [1:0] succ_c;

  // Lamp decode: only the four legal {main, side} patterns map to a phase.
  always_comb begin
    samp_c     = PH_MAIN_GREEN;
    conflict_c = 1'b1;
    case ({mon.main_red, mon.main_yellow, mon.main_green,
           mon.side_red, mon.side_yellow, mon.side_green})
      6'b001_100: begin samp_c = PH_MAIN_GREEN;  conflict_c = 1'b0; end
      6'b010_100: begin samp_c = PH_MAIN_YELLOW; conflict_c = 1'b0; end
      6'b100_001: begin samp_c = PH_SIDE_GREEN;  conflict_c = 1'b0; end
      6'b100_010: begin samp_c = PH_SIDE_YELLOW; conflict_c = 1'b0; end
      default:    begin samp_c = PH_MAIN_GREEN;  conflict_c = 1'b1; end
    endcase
  end

  assign succ_c = phase_q + 2'd1;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    code_d  = code_q;
    first_d = first_q;
    prev_d  = prev_q;
`ifdef TMON_DWELL_CHECK_EN
    dwell_d = dwell_q;
`endif

    case (state_q)
      ST_SYNC: begin
        if (conflict_c) begin
          state_d = ST_FAULT;
          code_d  = CODE_CONFLICT;
        end else if (samp_c == PH_MAIN_GREEN &&
                     (first_q || prev_q == PH_SIDE_YELLOW)) begin
          state_d = ST_TRACK;
          phase_d = PH_MAIN_GREEN;
          first_d = 1'b0;
          prev_d  = samp_c;
`ifdef TMON_DWELL_CHECK_EN
          dwell_d = CNT_W'(1);
`endif
        end else begin
          first_d = 1'b0;
          prev_d  = samp_c;
        end
      end

      ST_TRACK: begin
        // First matching check wins; a new phase is accepted only as the successor.
        if (conflict_c) begin
          state_d = ST_FAULT;
          code_d  = CODE_CONFLICT;
        end else if (samp_c != phase_q && samp_c != succ_c) begin
          state_d = ST_FAULT;
          code_d  = CODE_SEQ;
        end
`ifdef TMON_DWELL_CHECK_EN
        else if (samp_c == succ_c && dwell_q < DWELL_MAX) begin
          state_d = ST_FAULT;
          code_d  = CODE_EARLY;
        end else if (samp_c == phase_q && dwell_q == DWELL_MAX) begin
          state_d = ST_FAULT;
          code_d  = CODE_LATE;
        end else if (samp_c == succ_c) begin
          phase_d = samp_c;
          dwell_d = CNT_W'(1);
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
`else
        else if (samp_c == succ_c) begin
          phase_d = samp_c;
        end
`endif
      end

      ST_FAULT: begin
        if (mon.fault_clr) begin
          state_d = ST_SYNC;
          code_d  = CODE_NONE;
          first_d = 1'b1;
`ifdef TMON_DWELL_CHECK_EN
          dwell_d = '0;
`endif
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase

    locked_d = (state_d == ST_TRACK);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_SYNC;
      phase_q  <= PH_MAIN_GREEN;
      code_q   <= CODE_NONE;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      first_q  <= 1'b1;
      prev_q   <= PH_MAIN_GREEN;
`ifdef TMON_DWELL_CHECK_EN
      dwell_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      code_q   <= code_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      first_q  <= first_d;
      prev_q   <= prev_d;
`ifdef TMON_DWELL_CHECK_EN
      dwell_q  <= dwell_d;
`endif
    end
  end

  assign mon.phase      = phase_q;
  assign mon.locked     = locked_q;
  assign mon.fault      = fault_q;
  assign mon.fault_code = code_q;

endmodule
